// File: rtl/rsa_pkg.sv
// rsa_pkg
//   Declarations shared by the RSA datapath blocks: the modular
//   exponentiation sequencer state type, default widths, and the smallest
//   modulus the modulo lookup table can accept (the front end reuses it too).
package rsa_pkg;

   localparam int NUM_WIDTH_DEF = 12;
   localparam int N_WIDTH_DEF   = 6;
   localparam int E_WIDTH_DEF   = 6;

   // The modulo table is indexed by N-2, so no divisor below this may reach it.
   localparam int MIN_MODULUS   = 2;

   typedef enum logic [2:0] {
      IDLE,
      RED_ISS,
      RED_WAIT,
      SQ_ISS,
      SQ_WAIT,
      MUL_ISS,
      MUL_WAIT,
      DONE
   } modexp_state_t;

endpackage

// File: rtl/modexp_ctrl_if.sv
// modexp_ctrl_if
//   Request/response handshake between the RSA encrypt/decrypt front end
//   (master) and the modular exponentiation sequencer (slave).
//   master drives : start, base, exp, modulus
//   slave drives  : busy, done (1-cycle pulse), result, err
interface modexp_ctrl_if
   import rsa_pkg::*;
#(
   parameter int N_WIDTH = N_WIDTH_DEF,
   parameter int E_WIDTH = E_WIDTH_DEF
);
   logic               start;
   logic [N_WIDTH-1:0] base;
   logic [E_WIDTH-1:0] exp;
   logic [N_WIDTH-1:0] modulus;
   logic               busy;
   logic               done;
   logic [N_WIDTH-1:0] result;
   logic               err;

   modport master (
      output start, base, exp, modulus,
      input  busy, done, result, err
   );

   modport slave (
      input  start, base, exp, modulus,
      output busy, done, result, err
   );
endinterface

// File: rtl/bram.sv
// bram
//   Shared modulo lookup table: rem = num % N, registered, one cycle of
//   latency from num/N to rem. Callers keep N >= MIN_MODULUS.
//   clk : clock
//   num : dividend
//   N   : divisor
//   rem : registered remainder
module bram
   import rsa_pkg::*;
#(
   parameter int NUM_WIDTH = NUM_WIDTH_DEF,
   parameter int N_WIDTH   = N_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic [NUM_WIDTH-1:0] num,
   input  logic [N_WIDTH-1:0]   N,
   output logic [N_WIDTH-1:0]   rem
);

   logic [NUM_WIDTH-1:0] q;
   logic                 unused_q_hi;

   assign q = num % NUM_WIDTH'(N);

   // The remainder is always below N, so the upper quotient bits are zero.
   assign unused_q_hi = ^q[NUM_WIDTH-1:N_WIDTH];

   always_ff @(posedge clk) begin
      rem <= q[N_WIDTH-1:0];
   end

endmodule

// File: rtl/modexp_ctrl.sv
// modexp_ctrl
//   Computes result = base^exp mod modulus by left-to-right square-and-
//   multiply, using the external modulo table as its only reduction engine.
//   Every table access is an ISS/WAIT pair: lut_num/lut_N are loaded on entry
//   to ISS, held through WAIT, and lut_rem is captured at the edge ending WAIT.
//   clk, rst : clock, asynchronous active-high reset
//   req      : slave side of the start/done handshake
//   lut_num  : dividend to the modulo table
//   lut_N    : divisor to the modulo table, never below MIN_MODULUS
//   lut_rem  : table remainder, valid one cycle after lut_num/lut_N
module modexp_ctrl
   import rsa_pkg::*;
#(
   parameter int NUM_WIDTH = NUM_WIDTH_DEF,   // must be >= 2*N_WIDTH
   parameter int N_WIDTH   = N_WIDTH_DEF,
   parameter int E_WIDTH   = E_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   modexp_ctrl_if.slave         req,
   output logic [NUM_WIDTH-1:0] lut_num,
   output logic [N_WIDTH-1:0]   lut_N,
   input  logic [N_WIDTH-1:0]   lut_rem
);

   localparam int BIT_W = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

   modexp_state_t      state;
   logic [E_WIDTH-1:0] exp_r;
   logic [N_WIDTH-1:0] acc;
   logic [N_WIDTH-1:0] base_r;
   logic [BIT_W-1:0]   bit_idx;

   // Operands are already reduced below the modulus, so the 2*N_WIDTH
   // product cannot overflow; it is zero-extended to the table's width.
   function automatic logic [NUM_WIDTH-1:0] mulx(input logic [N_WIDTH-1:0] a,
                                                 input logic [N_WIDTH-1:0] b);
      logic [2*N_WIDTH-1:0] p;
      p = (2*N_WIDTH)'(a) * (2*N_WIDTH)'(b);
      return NUM_WIDTH'(p);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         req.busy   <= 1'b0;
         req.done   <= 1'b0;
         req.result <= '0;
         req.err    <= 1'b0;
         lut_num    <= '0;
         lut_N      <= N_WIDTH'(MIN_MODULUS);
         acc        <= '0;
         base_r     <= '0;
         bit_idx    <= '0;
         exp_r      <= '0;
      end else begin
         req.done <= 1'b0;
         case (state)
            IDLE: begin
               if (req.start) begin
                  exp_r   <= req.exp;
                  bit_idx <= BIT_W'(E_WIDTH - 1);
                  if (req.modulus < N_WIDTH'(MIN_MODULUS)) begin
                     // Unusable modulus: answer at once, never touch the table.
                     req.done   <= 1'b1;
                     req.result <= '0;
                     req.err    <= 1'b1;
                     state      <= DONE;
                  end else begin
                     acc      <= N_WIDTH'(1);
                     lut_num  <= NUM_WIDTH'(req.base);
                     lut_N    <= req.modulus;
                     req.busy <= 1'b1;
                     state    <= RED_ISS;
                  end
               end
            end
            RED_ISS: state <= RED_WAIT;
            RED_WAIT: begin
               base_r  <= lut_rem;
               lut_num <= mulx(acc, acc);
               state   <= SQ_ISS;
            end
            SQ_ISS: state <= SQ_WAIT;
            SQ_WAIT: begin
               // acc is updated this edge, so the next product uses lut_rem.
               acc <= lut_rem;
               if (exp_r[bit_idx]) begin
                  lut_num <= mulx(lut_rem, base_r);
                  state   <= MUL_ISS;
               end else if (bit_idx == '0) begin
                  req.result <= lut_rem;
                  req.err    <= 1'b0;
                  req.done   <= 1'b1;
                  req.busy   <= 1'b0;
                  state      <= DONE;
               end else begin
                  bit_idx <= bit_idx - 1'b1;
                  lut_num <= mulx(lut_rem, lut_rem);
                  state   <= SQ_ISS;
               end
            end
            MUL_ISS: state <= MUL_WAIT;
            MUL_WAIT: begin
               acc <= lut_rem;
               if (bit_idx == '0) begin
                  req.result <= lut_rem;
                  req.err    <= 1'b0;
                  req.done   <= 1'b1;
                  req.busy   <= 1'b0;
                  state      <= DONE;
               end else begin
                  bit_idx <= bit_idx - 1'b1;
                  lut_num <= mulx(lut_rem, lut_rem);
                  state   <= SQ_ISS;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
